// File: rtl/re_name_gen_if.sv
// Issue/commit bundle between the scoreboard (master) and the generation renamer (slave).
// Signal names keep the renamer's point of view: *_i flows into the renamer, *_o flows out.
//   issue_valid_i / issue_ack_i / issue_ack_o : per-slot in-order issue handshake
//   rs1_i, rs2_i, rs3_i, rd_i (+ *_fpr_i, rs3_valid_i) : architectural operands per slot
//   rs1_o, rs2_o, rs3_o, rd_o : renamed tags {gen, addr} per slot
//   commit_valid_i / commit_rd_i / commit_rd_fpr_i : writer retirement ports
interface re_name_gen_if #(
    parameter int unsigned ISSUE_WIDTH  = 2,
    parameter int unsigned COMMIT_PORTS = 2,
    parameter int unsigned NAME_BITS    = 2
) ();
    localparam int unsigned TW = 5 + NAME_BITS;

    logic [ISSUE_WIDTH-1:0]     issue_valid_i;
    logic [ISSUE_WIDTH-1:0]     issue_ack_i;
    logic [ISSUE_WIDTH-1:0]     issue_ack_o;
    logic [ISSUE_WIDTH*5-1:0]   rs1_i;
    logic [ISSUE_WIDTH*5-1:0]   rs2_i;
    logic [ISSUE_WIDTH*5-1:0]   rs3_i;
    logic [ISSUE_WIDTH*5-1:0]   rd_i;
    logic [ISSUE_WIDTH-1:0]     rs1_fpr_i;
    logic [ISSUE_WIDTH-1:0]     rs2_fpr_i;
    logic [ISSUE_WIDTH-1:0]     rd_fpr_i;
    logic [ISSUE_WIDTH-1:0]     rs3_valid_i;
    logic [ISSUE_WIDTH*TW-1:0]  rs1_o;
    logic [ISSUE_WIDTH*TW-1:0]  rs2_o;
    logic [ISSUE_WIDTH*TW-1:0]  rs3_o;
    logic [ISSUE_WIDTH*TW-1:0]  rd_o;
    logic [COMMIT_PORTS-1:0]    commit_valid_i;
    logic [COMMIT_PORTS*5-1:0]  commit_rd_i;
    logic [COMMIT_PORTS-1:0]    commit_rd_fpr_i;

    modport master (
        output issue_valid_i, issue_ack_i, rs1_i, rs2_i, rs3_i, rd_i,
        output rs1_fpr_i, rs2_fpr_i, rd_fpr_i, rs3_valid_i,
        output commit_valid_i, commit_rd_i, commit_rd_fpr_i,
        input  issue_ack_o, rs1_o, rs2_o, rs3_o, rd_o
    );

    modport slave (
        input  issue_valid_i, issue_ack_i, rs1_i, rs2_i, rs3_i, rd_i,
        input  rs1_fpr_i, rs2_fpr_i, rd_fpr_i, rs3_valid_i,
        input  commit_valid_i, commit_rd_i, commit_rd_fpr_i,
        output issue_ack_o, rs1_o, rs2_o, rs3_o, rd_o
    );
endinterface

// File: rtl/re_name_gen.sv
// Multi-issue generation renamer. Every GPR/FPR keeps a NAME_BITS generation counter and an
// in-flight writer count; issuing a writer bumps both, commits decrement the count, and a slot
// stalls when its new generation would alias a writer still in flight.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             clear all generations, counts and underflow_o on the next edge
//   flush_unissued_i    block issue-side table updates this cycle (commits still apply)
//   bus (slave)         issue handshake, operands, renamed tags, commit ports
//   underflow_o         sticky: a commit arrived for a register with no writer in flight
//   stall_cnt_o         saturating count of cycles with a stalled, otherwise ready slot
//                       (present only when RE_NAME_GEN_STATS_EN is defined)
module re_name_gen #(
    parameter int unsigned ISSUE_WIDTH   = 2,
    parameter int unsigned COMMIT_PORTS  = 2,
    parameter int unsigned NAME_BITS     = 2,
    parameter int unsigned ENABLE_RENAME = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         flush_unissued_i,
    re_name_gen_if.slave bus,
    output logic         underflow_o
`ifdef RE_NAME_GEN_STATS_EN
    ,
    output logic [31:0]  stall_cnt_o
`endif
);
    localparam int unsigned TW  = 5 + NAME_BITS;
    localparam int          MAX = (1 << NAME_BITS) - 1;
    localparam bit          EN  = (ENABLE_RENAME != 0);

    typedef logic [NAME_BITS-1:0] gen_t;
    typedef logic [NAME_BITS:0]   cnt_t;

    gen_t gen_q [2][32];
    gen_t gen_d [2][32];
    cnt_t cnt_q [2][32];
    cnt_t cnt_d [2][32];
    logic underflow_q, underflow_d;

    logic [ISSUE_WIDTH-1:0] wr;      // slot writes a renamable register
    logic [ISSUE_WIDTH-1:0] stall;
    logic [ISSUE_WIDTH-1:0] ack;
    gen_t                   rd_gen [ISSUE_WIDTH];

    function automatic logic is_x0(input logic f, input logic [4:0] a);
        return !f && (a == 5'd0);
    endfunction

    // Acceptance chain and destination generations. Lower slots are resolved first so a later
    // slot sees both the forwarded generation and the extra in-flight writers of its predecessors.
    always_comb begin : accept_comb
        logic        prev;
        logic        f;
        logic [4:0]  a;
        gen_t        g;
        int          eff;
        wr    = '0;
        stall = '0;
        ack   = '0;
        prev  = 1'b1;
        f     = 1'b0;
        a     = '0;
        g     = '0;
        eff   = 0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            rd_gen[i] = '0;
        end
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            f     = bus.rd_fpr_i[i];
            a     = bus.rd_i[i*5 +: 5];
            wr[i] = !is_x0(f, a);
            g     = gen_q[f][a];
            eff   = int'(cnt_q[f][a]);
            for (int unsigned j = 0; j < ISSUE_WIDTH; j++) begin
                if (j < i && ack[j] && wr[j] && bus.rd_fpr_i[j] == f &&
                    bus.rd_i[j*5 +: 5] == a) begin
                    g   = rd_gen[j];
                    eff = eff + 1;
                end
            end
            for (int unsigned k = 0; k < COMMIT_PORTS; k++) begin
                if (bus.commit_valid_i[k] && bus.commit_rd_fpr_i[k] == f &&
                    bus.commit_rd_i[k*5 +: 5] == a) begin
                    eff = eff - 1;
                end
            end
            stall[i]  = EN && wr[i] && (eff >= MAX);
            ack[i]    = bus.issue_valid_i[i] && bus.issue_ack_i[i] && prev && !stall[i];
            prev      = ack[i];
            rd_gen[i] = (EN && wr[i]) ? gen_t'(g + gen_t'(1)) : '0;
        end
    end

    // Source tags: table generation, overridden by the last accepted lower writer of the same reg.
    always_comb begin : source_comb
        logic        f;
        logic [4:0]  a;
        logic        use_gen;
        gen_t        g;
        bus.rs1_o = '0;
        bus.rs2_o = '0;
        bus.rs3_o = '0;
        bus.rd_o  = '0;
        f         = 1'b0;
        a         = '0;
        use_gen   = 1'b0;
        g         = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            for (int unsigned op = 0; op < 3; op++) begin
                case (op)
                    0: begin
                        f       = bus.rs1_fpr_i[i];
                        a       = bus.rs1_i[i*5 +: 5];
                        use_gen = 1'b1;
                    end
                    1: begin
                        f       = bus.rs2_fpr_i[i];
                        a       = bus.rs2_i[i*5 +: 5];
                        use_gen = 1'b1;
                    end
                    default: begin
                        f       = 1'b1;
                        a       = bus.rs3_i[i*5 +: 5];
                        use_gen = bus.rs3_valid_i[i];
                    end
                endcase
                g = gen_q[f][a];
                for (int unsigned j = 0; j < ISSUE_WIDTH; j++) begin
                    if (j < i && ack[j] && wr[j] && bus.rd_fpr_i[j] == f &&
                        bus.rd_i[j*5 +: 5] == a) begin
                        g = rd_gen[j];
                    end
                end
                if (!EN || is_x0(f, a) || !use_gen) begin
                    g = '0;
                end
                case (op)
                    0:       bus.rs1_o[i*TW +: TW] = {g, a};
                    1:       bus.rs2_o[i*TW +: TW] = {g, a};
                    default: bus.rs3_o[i*TW +: TW] = {g, a};
                endcase
            end
            bus.rd_o[i*TW +: TW] = {rd_gen[i], bus.rd_i[i*5 +: 5]};
        end
        bus.issue_ack_o = ack;
    end

    // Table update: per register, net = +accepted issues - commits, clamped at zero.
    always_comb begin : table_comb
        logic        f;
        logic [4:0]  a;
        gen_t        g;
        int          net;
        gen_d       = gen_q;
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        f           = 1'b0;
        a           = '0;
        g           = '0;
        net         = 0;
        if (flush_i) begin
            gen_d       = '{default: '0};
            cnt_d       = '{default: '0};
            underflow_d = 1'b0;
        end else if (EN) begin
            for (int unsigned fi = 0; fi < 2; fi++) begin
                for (int unsigned ai = 0; ai < 32; ai++) begin
                    f = fi[0];
                    a = ai[4:0];
                    if (!is_x0(f, a)) begin
                        net = int'(cnt_q[f][a]);
                        g   = gen_q[f][a];
                        if (!flush_unissued_i) begin
                            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                                if (ack[i] && wr[i] && bus.rd_fpr_i[i] == f &&
                                    bus.rd_i[i*5 +: 5] == a) begin
                                    net = net + 1;
                                    g   = rd_gen[i];
                                end
                            end
                        end
                        for (int unsigned k = 0; k < COMMIT_PORTS; k++) begin
                            if (bus.commit_valid_i[k] && bus.commit_rd_fpr_i[k] == f &&
                                bus.commit_rd_i[k*5 +: 5] == a) begin
                                net = net - 1;
                            end
                        end
                        if (net < 0) begin
                            net         = 0;
                            underflow_d = 1'b1;
                        end
                        gen_d[f][a] = g;
                        cnt_d[f][a] = cnt_t'(net);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gen_q       <= '{default: '0};
            cnt_q       <= '{default: '0};
            underflow_q <= 1'b0;
        end else begin
            gen_q       <= gen_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign underflow_o = underflow_q;

`ifdef RE_NAME_GEN_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_any;

    always_comb begin
        stall_any   = |(bus.issue_valid_i & bus.issue_ack_i & stall);
        stall_cnt_d = stall_cnt_q;
        if (stall_any && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Only reset clears the statistic; flush_i intentionally leaves it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_re_name_gen.sv
module tb_re_name_gen;
    localparam int unsigned IW = 2;
    localparam int unsigned CP = 2;
    localparam int unsigned NB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush_unissued = 1'b0;
    logic underflow;
`ifdef RE_NAME_GEN_STATS_EN
    logic [31:0] stall_cnt;
`endif

    re_name_gen_if #(.ISSUE_WIDTH(IW), .COMMIT_PORTS(CP), .NAME_BITS(NB)) bus ();

    re_name_gen #(
        .ISSUE_WIDTH  (IW),
        .COMMIT_PORTS (CP),
        .NAME_BITS    (NB),
        .ENABLE_RENAME(1)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .flush_unissued_i(flush_unissued),
        .bus             (bus),
        .underflow_o     (underflow)
`ifdef RE_NAME_GEN_STATS_EN
        ,
        .stall_cnt_o     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic expect_v(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            e = '{"empty_scoreboard", 32'hDEAD_BEEF};
        end else begin
            e = sb.pop_front();
        end
        n_assert++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic idle();
        bus.issue_valid_i   = '0;
        bus.issue_ack_i     = '1;
        bus.rs1_i           = '0;
        bus.rs2_i           = '0;
        bus.rs3_i           = '0;
        bus.rd_i            = '0;
        bus.rs1_fpr_i       = '0;
        bus.rs2_fpr_i       = '0;
        bus.rd_fpr_i        = '0;
        bus.rs3_valid_i     = '0;
        bus.commit_valid_i  = '0;
        bus.commit_rd_i     = '0;
        bus.commit_rd_fpr_i = '0;
        flush               = 1'b0;
        flush_unissued      = 1'b0;
    endtask

    task automatic set_slot(input int s, input logic v, input logic [4:0] rd, input logic rdf);
        bus.issue_valid_i[s] = v;
        bus.rd_i[s*5 +: 5]   = rd;
        bus.rd_fpr_i[s]      = rdf;
    endtask

    task automatic set_src(input int s, input logic [4:0] rs1, input logic rs1f,
                           input logic [4:0] rs2, input logic [4:0] rs3, input logic rs3v);
        bus.rs1_i[s*5 +: 5] = rs1;
        bus.rs1_fpr_i[s]    = rs1f;
        bus.rs2_i[s*5 +: 5] = rs2;
        bus.rs2_fpr_i[s]    = 1'b0;
        bus.rs3_i[s*5 +: 5] = rs3;
        bus.rs3_valid_i[s]  = rs3v;
    endtask

    task automatic set_commit(input int k, input logic v, input logic [4:0] rd, input logic f);
        bus.commit_valid_i[k]     = v;
        bus.commit_rd_i[k*5 +: 5] = rd;
        bus.commit_rd_fpr_i[k]    = f;
    endtask

    // Tag {gen, addr} for NAME_BITS=2
    function automatic logic [31:0] tg(input int g, input int a);
        return 32'((g << 5) | a);
    endfunction

    initial begin
        idle();
        // Reset state: identity tags, no underflow
        set_src(0, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0);
        #2;
        expect_v("reset_underflow", 0);
        expect_v("reset_rs1_identity", tg(0, 5));
        chk(32'(underflow));
        chk(32'(bus.rs1_o[0 +: 7]));
        @(negedge clk);
        rst_n = 1'b1;

        // Single writer x5
        @(negedge clk);
        idle();
        set_slot(0, 1'b1, 5'd5, 1'b0);
        expect_v("x5_ack", 32'b01);
        expect_v("x5_rd_tag", tg(1, 5));
        #2;
        chk(32'(bus.issue_ack_o));
        chk(32'(bus.rd_o[0 +: 7]));

        @(negedge clk);
        idle();
        set_src(0, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_v("x5_rs1_after", tg(1, 5));
        #2;
        chk(32'(bus.rs1_o[0 +: 7]));

        // Intra-bundle forwarding on x3
        @(negedge clk);
        idle();
        set_slot(0, 1'b1, 5'd3, 1'b0);
        set_slot(1, 1'b1, 5'd3, 1'b0);
        set_src(1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_v("fwd_ack", 32'b11);
        expect_v("fwd_slot0_rd", tg(1, 3));
        expect_v("fwd_slot1_rs1", tg(1, 3));
        expect_v("fwd_slot1_rd", tg(2, 3));
        #2;
        chk(32'(bus.issue_ack_o));
        chk(32'(bus.rd_o[0 +: 7]));
        chk(32'(bus.rs1_o[7 +: 7]));
        chk(32'(bus.rd_o[7 +: 7]));

        @(negedge clk);
        idle();
        set_src(0, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_v("x3_gen_after", tg(2, 3));
        #2;
        chk(32'(bus.rs1_o[0 +: 7]));

        // x7 three times, then the fourth stalls
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            idle();
            set_slot(0, 1'b1, 5'd7, 1'b0);
            expect_v($sformatf("x7_issue%0d_rd", n), tg(n, 7));
            #2;
            chk(32'(bus.rd_o[0 +: 7]));
        end
        @(negedge clk);
        idle();
        set_slot(0, 1'b1, 5'd7, 1'b0);
        set_slot(1, 1'b1, 5'd8, 1'b0);
        expect_v("x7_stall_ack", 32'b00);
        #2;
        chk(32'(bus.issue_ack_o));
        set_commit(0, 1'b1, 5'd7, 1'b0);
        expect_v("x7_commit_ack", 32'b11);
        expect_v("x7_wrap_rd", tg(0, 7));
        expect_v("x8_rd", tg(1, 8));
        #1;
        chk(32'(bus.issue_ack_o));
        chk(32'(bus.rd_o[0 +: 7]));
        chk(32'(bus.rd_o[7 +: 7]));

        @(negedge clk);
        idle();
        set_src(0, 5'd7, 1'b0, 5'd8, 5'd0, 1'b0);
        expect_v("x7_rs1_wrapped", tg(0, 7));
        expect_v("x8_rs2", tg(1, 8));
        #2;
        chk(32'(bus.rs1_o[0 +: 7]));
        chk(32'(bus.rs2_o[0 +: 7]));

        // x0 writer and x0 commit
        @(negedge clk);
        idle();
        set_slot(0, 1'b1, 5'd0, 1'b0);
        set_src(1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        set_commit(1, 1'b1, 5'd0, 1'b0);
        expect_v("x0_ack", 32'b01);
        expect_v("x0_rd", tg(0, 0));
        expect_v("x0_fwd_rs1", tg(0, 0));
        #2;
        chk(32'(bus.issue_ack_o));
        chk(32'(bus.rd_o[0 +: 7]));
        chk(32'(bus.rs1_o[7 +: 7]));

        // f2 writer with rs3 forwarding; underflow must still be clear after x0 commit
        @(negedge clk);
        idle();
        set_slot(0, 1'b1, 5'd2, 1'b1);
        set_src(1, 5'd0, 1'b0, 5'd0, 5'd2, 1'b1);
        expect_v("x0_no_underflow", 0);
        expect_v("f2_rs3_fwd", tg(1, 2));
        #2;
        chk(32'(underflow));
        chk(32'(bus.rs3_o[7 +: 7]));
        bus.rs3_valid_i[1] = 1'b0;
        expect_v("f2_rs3_invalid", tg(0, 2));
        #1;
        chk(32'(bus.rs3_o[7 +: 7]));

        // Register-file separation, and commit to f4 with nothing in flight
        @(negedge clk);
        idle();
        set_src(0, 5'd2, 1'b1, 5'd0, 5'd0, 1'b0);
        set_src(1, 5'd2, 1'b0, 5'd0, 5'd0, 1'b0);
        set_commit(0, 1'b1, 5'd4, 1'b1);
        expect_v("f2_rs1", tg(1, 2));
        expect_v("x2_rs1", tg(0, 2));
        expect_v("f4_pre_underflow", 0);
        #2;
        chk(32'(bus.rs1_o[0 +: 7]));
        chk(32'(bus.rs1_o[7 +: 7]));
        chk(32'(underflow));

        // Flush: outputs still pre-flush this cycle, identity afterwards
        @(negedge clk);
        idle();
        flush = 1'b1;
        set_src(0, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_v("f4_underflow", 1);
        expect_v("flush_cycle_rs1", tg(1, 5));
        #2;
        chk(32'(underflow));
        chk(32'(bus.rs1_o[0 +: 7]));

        @(negedge clk);
        idle();
        set_src(0, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0);
        set_src(1, 5'd3, 1'b0, 5'd0, 5'd0, 1'b0);
        expect_v("post_flush_underflow", 0);
        expect_v("post_flush_x5", tg(0, 5));
        expect_v("post_flush_x3", tg(0, 3));
        #2;
        chk(32'(underflow));
        chk(32'(bus.rs1_o[0 +: 7]));
        chk(32'(bus.rs1_o[7 +: 7]));

        // flush_unissued: accepted but the table does not move
        @(negedge clk);
        idle();
        flush_unissued = 1'b1;
        set_slot(0, 1'b1, 5'd9, 1'b0);
        expect_v("fu_ack", 32'b01);
        expect_v("fu_rd", tg(1, 9));
        #2;
        chk(32'(bus.issue_ack_o));
        chk(32'(bus.rd_o[0 +: 7]));

        @(negedge clk);
        idle();
        set_slot(0, 1'b1, 5'd9, 1'b0);
        expect_v("fu_rd_unchanged", tg(1, 9));
        #2;
        chk(32'(bus.rd_o[0 +: 7]));

`ifdef RE_NAME_GEN_STATS_EN
        // Fill x10 to the limit, then hold a stalled request for five edges
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            idle();
            set_slot(0, 1'b1, 5'd10, 1'b0);
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            idle();
            set_slot(0, 1'b1, 5'd10, 1'b0);
        end
        @(negedge clk);
        idle();
        expect_v("stall_cnt", 5);
        #2;
        chk(stall_cnt);
`endif

        @(negedge clk);
        idle();
        expect_v("scoreboard_drained", 1);
        #2;
        chk(32'(sb.size() == 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
